// File: rtl/wb_commit_stage_if.sv
// MEM-to-WB bundle handshake, register-file write ports and debug trace port of wb_commit_stage.
interface wb_commit_stage_if #(
  parameter int unsigned LANES = 2
);
  logic                  ms_valid;
  logic                  ws_allowin;
  logic [LANES-1:0]      ms_lane_valid;
  logic [32*LANES-1:0]   ms_pc;
  logic [4*LANES-1:0]    ms_rf_we;
  logic [5*LANES-1:0]    ms_dest;
  logic [32*LANES-1:0]   ms_result;
  logic [LANES-1:0]      ms_ex;
  logic [LANES-1:0]      ms_eret;
  logic [4*LANES-1:0]    rf_we;
  logic [5*LANES-1:0]    rf_waddr;
  logic [32*LANES-1:0]   rf_wdata;
  logic                  ws_ex_en;
  logic                  ws_eret_flush;
  logic [31:0]           ws_ex_pc;
  logic [31:0]           debug_wb_pc;
  logic [3:0]            debug_wb_rf_wen;
  logic [4:0]            debug_wb_rf_wnum;
  logic [31:0]           debug_wb_rf_wdata;

  modport master (
    output ms_valid, ms_lane_valid, ms_pc, ms_rf_we, ms_dest, ms_result, ms_ex, ms_eret,
    input  ws_allowin, rf_we, rf_waddr, rf_wdata, ws_ex_en, ws_eret_flush, ws_ex_pc,
    input  debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata
  );

  modport slave (
    input  ms_valid, ms_lane_valid, ms_pc, ms_rf_we, ms_dest, ms_result, ms_ex, ms_eret,
    output ws_allowin, rf_we, rf_waddr, rf_wdata, ws_ex_en, ws_eret_flush, ws_ex_pc,
    output debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata
  );
endinterface

// File: rtl/wb_commit_stage.sv
// Multi-lane writeback/commit stage: in-order exception/ERET precedence, per-lane RF writes,
// and a trace FIFO that serialises committed lanes onto the single debug trace port.
module wb_commit_stage #(
  parameter int unsigned LANES       = 2,
  parameter int unsigned TRACE_DEPTH = 8
) (
  input logic              clk,
  input logic              resetn,
  wb_commit_stage_if.slave bus
);

  localparam int unsigned AW = $clog2(TRACE_DEPTH);

  typedef logic [AW:0] ptr_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [3:0]  we;
    logic [4:0]  dest;
    logic [31:0] data;
  } trace_t;

  logic                ws_valid_q, ws_valid_d;
  logic [LANES-1:0]    lane_valid_q, lane_valid_d;
  logic [LANES-1:0]    ex_q, ex_d;
  logic [LANES-1:0]    eret_q, eret_d;
  logic [32*LANES-1:0] pc_q, pc_d;
  logic [32*LANES-1:0] result_q, result_d;
  logic [4*LANES-1:0]  we_q, we_d;
  logic [5*LANES-1:0]  dest_q, dest_d;

  ptr_t                wr_ptr_q, wr_ptr_d;
  ptr_t                rd_ptr_q, rd_ptr_d;
  ptr_t                count;
  ptr_t                push_cnt;
  ptr_t                push_off [LANES];
  logic [AW-1:0]       wr_idx   [LANES];
  trace_t              push_ent [LANES];
  trace_t              mem_q    [TRACE_DEPTH];
  trace_t              head;
  trace_t              last_q, last_d;
  logic [AW+1:0]       occ_next;

  logic [LANES-1:0]    commit;
  logic [LANES-1:0]    push_lane;
  logic                flush_ex, flush_eret;
  logic [31:0]         flush_pc;
  logic                allowin;
  logic                accept;
  logic                pop;

  // Walk lanes oldest-first; the first excepting/ERET lane traces but does not write,
  // and everything younger than it is killed.
  always_comb begin : p_prec
    logic seen;
    seen       = 1'b0;
    commit     = '0;
    push_lane  = '0;
    flush_ex   = 1'b0;
    flush_eret = 1'b0;
    flush_pc   = '0;
    for (int i = 0; i < LANES; i++) begin
      if (ws_valid_q && lane_valid_q[i] && !seen) begin
        push_lane[i] = 1'b1;
        if (ex_q[i] || eret_q[i]) begin
          seen       = 1'b1;
          flush_ex   = ex_q[i];
          flush_eret = eret_q[i] & ~ex_q[i];
          flush_pc   = pc_q[32*i +: 32];
        end else begin
          commit[i] = 1'b1;
        end
      end
    end
  end

  // Compact pushing lanes into consecutive FIFO slots in lane order.
  always_comb begin
    push_cnt = '0;
    for (int i = 0; i < LANES; i++) begin
      push_off[i] = push_cnt;
      wr_idx[i]   = AW'(wr_ptr_q + push_cnt);
      push_ent[i] = '{pc:   pc_q[32*i +: 32],
                      we:   commit[i] ? we_q[4*i +: 4] : 4'b0,
                      dest: dest_q[5*i +: 5],
                      data: result_q[32*i +: 32]};
      if (push_lane[i]) begin
        push_cnt = push_cnt + ptr_t'(1);
      end
    end
  end

  always_comb begin
    count    = wr_ptr_q - rd_ptr_q;
    pop      = (count != '0);
    head     = mem_q[rd_ptr_q[AW-1:0]];
    occ_next = {1'b0, count} + {1'b0, push_cnt} - {{(AW+1){1'b0}}, pop};
    allowin  = (occ_next <= (AW+2)'(TRACE_DEPTH - LANES));
    accept   = bus.ms_valid & allowin & ~(flush_ex | flush_eret);
    wr_ptr_d = wr_ptr_q + push_cnt;
    rd_ptr_d = rd_ptr_q + ptr_t'(pop);
    last_d   = pop ? head : last_q;
  end

  always_comb begin
    ws_valid_d   = accept;
    lane_valid_d = lane_valid_q;
    ex_d         = ex_q;
    eret_d       = eret_q;
    pc_d         = pc_q;
    result_d     = result_q;
    we_d         = we_q;
    dest_d       = dest_q;
    if (accept) begin
      lane_valid_d = bus.ms_lane_valid;
      ex_d         = bus.ms_ex;
      eret_d       = bus.ms_eret;
      pc_d         = bus.ms_pc;
      result_d     = bus.ms_result;
      we_d         = bus.ms_rf_we;
      dest_d       = bus.ms_dest;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ws_valid_q   <= 1'b0;
      lane_valid_q <= '0;
      ex_q         <= '0;
      eret_q       <= '0;
      pc_q         <= '0;
      result_q     <= '0;
      we_q         <= '0;
      dest_q       <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      last_q       <= '0;
    end else begin
      ws_valid_q   <= ws_valid_d;
      lane_valid_q <= lane_valid_d;
      ex_q         <= ex_d;
      eret_q       <= eret_d;
      pc_q         <= pc_d;
      result_q     <= result_d;
      we_q         <= we_d;
      dest_q       <= dest_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      last_q       <= last_d;
    end
  end

  // Storage needs no reset: the pointers alone decide what is visible.
  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (push_lane[i]) begin
        mem_q[wr_idx[i]] <= push_ent[i];
      end
    end
  end

  always_comb begin
    bus.ws_allowin    = allowin;
    bus.rf_waddr      = dest_q;
    bus.rf_wdata      = result_q;
    bus.ws_ex_en      = flush_ex;
    bus.ws_eret_flush = flush_eret;
    bus.ws_ex_pc      = flush_pc;
    for (int i = 0; i < LANES; i++) begin
      bus.rf_we[4*i +: 4] = commit[i] ? we_q[4*i +: 4] : 4'b0;
    end
    bus.debug_wb_pc       = pop ? head.pc   : last_q.pc;
    bus.debug_wb_rf_wen   = pop ? head.we   : 4'b0;
    bus.debug_wb_rf_wnum  = pop ? head.dest : last_q.dest;
    bus.debug_wb_rf_wdata = pop ? head.data : last_q.data;
  end

endmodule
